// File: rtl/chip_74109_model_if.sv
// chip_74109_model_if: socket pin bundle between the 74109 tester (master) and the chip model (slave).
// FaultSel exists only when CHIP_74109_FAULT_EN is defined.
`default_nettype none

interface chip_74109_model_if #(
  parameter int CNT_W = 8
);
  logic             Pin1;
  logic             Pin2;
  logic             Pin4;
  logic             Pin5;
  logic             Pin9;
  logic             Pin10;
  logic             Pin12;
  logic             Pin13;
  logic             Pin3;
  logic             Pin6;
  logic             Pin8;
  logic             Pin11;
  logic [CNT_W-1:0] EdgeCnt1;
  logic [CNT_W-1:0] EdgeCnt2;
`ifdef CHIP_74109_FAULT_EN
  logic [1:0]       FaultSel;

  modport master (
    output Pin1, Pin2, Pin4, Pin5, Pin9, Pin10, Pin12, Pin13, FaultSel,
    input  Pin3, Pin6, Pin8, Pin11, EdgeCnt1, EdgeCnt2
  );
  modport slave (
    input  Pin1, Pin2, Pin4, Pin5, Pin9, Pin10, Pin12, Pin13, FaultSel,
    output Pin3, Pin6, Pin8, Pin11, EdgeCnt1, EdgeCnt2
  );
`else
  modport master (
    output Pin1, Pin2, Pin4, Pin5, Pin9, Pin10, Pin12, Pin13,
    input  Pin3, Pin6, Pin8, Pin11, EdgeCnt1, EdgeCnt2
  );
  modport slave (
    input  Pin1, Pin2, Pin4, Pin5, Pin9, Pin10, Pin12, Pin13,
    output Pin3, Pin6, Pin8, Pin11, EdgeCnt1, EdgeCnt2
  );
`endif
endinterface

`default_nettype wire

// File: rtl/chip_74109_model.sv
// chip_74109_model: behavioural dual J-K(bar) flip-flop (74109) driving the socket output pins.
// Optional output fault injection via macro CHIP_74109_FAULT_EN.
`default_nettype none

module chip_74109_model #(
  parameter int SYNC_STAGES = 2,   // legal range 2..4
  parameter int CNT_W       = 8
) (
  input  wire logic          Clk,
  input  wire logic          Reset,
  chip_74109_model_if.slave  bus
);

  // Bit map: 0 CLR1_n, 1 J1, 2 K1_n, 3 CLK1, 4 CLR2_n, 5 J2, 6 K2_n, 7 CLK2
  logic [7:0]             w_pins;
  logic [7:0]             r_sync [SYNC_STAGES];
  logic [7:0]             w_s;
  logic [1:0]             r_clk_prev;
  logic [SYNC_STAGES:0]   r_vld;
  logic [1:0]             w_clr_n;
  logic [1:0]             w_j;
  logic [1:0]             w_k;
  logic [1:0]             w_rise;
  logic [1:0]             w_qual;
  logic [1:0]             r_q;
  logic [1:0]             w_q_nxt;
  logic [CNT_W-1:0]       r_cnt1;
  logic [CNT_W-1:0]       r_cnt2;

  assign w_pins  = {bus.Pin9, bus.Pin10, bus.Pin12, bus.Pin13,
                    bus.Pin5, bus.Pin4,  bus.Pin2,  bus.Pin1};
  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_clr_n = {w_s[4], w_s[0]};
  assign w_j     = {w_s[5], w_s[1]};
  assign w_k     = {w_s[6], w_s[2]};

  // Edges are only honoured once both the synchroniser and the previous-value
  // register hold post-reset samples, so a CLK already high at release is not an edge.
  assign w_rise  = {w_s[7], w_s[3]} & ~r_clk_prev & {2{r_vld[SYNC_STAGES]}};
  assign w_qual  = w_rise & w_clr_n;

  always_comb begin
    w_q_nxt = r_q;
    for (int n = 0; n < 2; n++) begin
      if (!w_clr_n[n]) begin
        w_q_nxt[n] = 1'b0;
      end else if (w_rise[n]) begin
        unique case ({w_j[n], w_k[n]})
          2'b00: w_q_nxt[n] = 1'b0;
          2'b11: w_q_nxt[n] = 1'b1;
          2'b01: w_q_nxt[n] = r_q[n];
          2'b10: w_q_nxt[n] = ~r_q[n];
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_clk_prev <= '0;
      r_vld      <= '0;
      r_q        <= '0;
      r_cnt1     <= '0;
      r_cnt2     <= '0;
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_clk_prev <= {w_s[7], w_s[3]};
      r_vld      <= {r_vld[SYNC_STAGES-1:0], 1'b1};
      r_q        <= w_q_nxt;
      r_cnt1     <= r_cnt1 + CNT_W'(w_qual[0]);
      r_cnt2     <= r_cnt2 + CNT_W'(w_qual[1]);
    end
  end

  assign bus.EdgeCnt1 = r_cnt1;
  assign bus.EdgeCnt2 = r_cnt2;

`ifdef CHIP_74109_FAULT_EN
  logic [1:0] r_fault;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_fault <= 2'b00;
    end else begin
      r_fault <= bus.FaultSel;
    end
  end

  // Faults touch only the pins; r_q and the counters keep the true state.
  assign bus.Pin3  = (r_fault == 2'b01) ? 1'b0 : r_q[0];
  assign bus.Pin6  = (r_fault == 2'b11) ? r_q[0] : ~r_q[0];
  assign bus.Pin11 = (r_fault == 2'b10) ? 1'b1 : r_q[1];
  assign bus.Pin8  = ~r_q[1];
`else
  assign bus.Pin3  = r_q[0];
  assign bus.Pin6  = ~r_q[0];
  assign bus.Pin11 = r_q[1];
  assign bus.Pin8  = ~r_q[1];
`endif

endmodule

`default_nettype wire
